// File: rtl/ft245_pkg.sv
// Shared types and timing defaults for the FT245 async FIFO bus controller.
package ft245_pkg;
  localparam int CNT_W        = 4;
  localparam int RD_PULSE_DEF = 4;
  localparam int RD_RECOV_DEF = 4;
  localparam int WR_PULSE_DEF = 4;
  localparam int WR_HOLD_DEF  = 2;
  localparam int GUARD_DEF    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_RD_RECOV,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_GUARD_WAIT
  } state_t;

  // Timing counters load N-1 and count down to zero, giving exactly N cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction
endpackage

// File: rtl/ft245_sync.sv
// Two-flop synchroniser for FT245 status flags; resets to 1 so flags read inactive.
module ft245_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_s1, r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/ft245_ctrl.sv
// FT245 bus sequencer: arbitrates TX/RX bytes onto the shared 8-bit bus with timed strobes.
// Define FT245_RR_ARB_EN for round-robin arbitration; default is fixed read priority.
module ft245_ctrl
  import ft245_pkg::*;
#(
  parameter int RD_PULSE = RD_PULSE_DEF,
  parameter int RD_RECOV = RD_RECOV_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF,
  parameter int WR_HOLD  = WR_HOLD_DEF,
  parameter int GUARD    = GUARD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxf_n,
  input  logic       txe_n,
  input  logic [7:0] d_i,
  output logic [7:0] d_o,
  output logic       d_oe,
  output logic       rd_n,
  output logic       wr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy
);
  logic w_rxf_s, w_txe_s;

  ft245_sync u_rxf_sync (.clk(clk), .rst_n(rst_n), .i_d(rxf_n), .o_q(w_rxf_s));
  ft245_sync u_txe_sync (.clk(clk), .rst_n(rst_n), .i_d(txe_n), .o_q(w_txe_s));

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_gcnt;
  logic             r_rd_n, r_wr, r_d_oe, r_rx_valid;
  logic [7:0]       r_d_o, r_rx_data;

  logic w_decide, w_rd_req, w_wr_req, w_rd_grant, w_wr_grant;

  // A held rx byte blocks further reads so backpressure stays in the device FIFO.
  assign w_decide = (r_state == ST_IDLE) && (r_gcnt == '0);
  assign w_rd_req = !w_rxf_s && !r_rx_valid;
  assign w_wr_req = !w_txe_s && tx_valid;

`ifdef FT245_RR_ARB_EN
  logic r_last_wr;

  assign w_rd_grant = w_decide && w_rd_req && (!w_wr_req || r_last_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last_wr <= 1'b1;
    else if (w_rd_grant) r_last_wr <= 1'b0;
    else if (w_wr_grant) r_last_wr <= 1'b1;
  end
`else
  assign w_rd_grant = w_decide && w_rd_req;
`endif

  assign w_wr_grant = w_decide && w_wr_req && !w_rd_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_gcnt     <= '0;
      r_rd_n     <= 1'b1;
      r_wr       <= 1'b0;
      r_d_oe     <= 1'b0;
      r_d_o      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rd_grant) begin
            r_rd_n  <= 1'b0;
            r_cnt   <= cnt_load(RD_PULSE);
            r_state <= ST_RD_STROBE;
          end else if (w_wr_grant) begin
            r_d_o   <= tx_data;
            r_d_oe  <= 1'b1;
            r_wr    <= 1'b1;
            r_cnt   <= cnt_load(WR_PULSE);
            r_state <= ST_WR_STROBE;
          end
        end
        ST_RD_STROBE: begin
          if (r_cnt == '0) begin
            r_rd_n     <= 1'b1;
            r_rx_data  <= d_i;
            r_rx_valid <= 1'b1;
            r_cnt      <= cnt_load(RD_RECOV);
            r_state    <= ST_RD_RECOV;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RD_RECOV: begin
          if (r_cnt == '0) begin
            r_gcnt  <= cnt_load(GUARD);
            r_state <= ST_GUARD_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WR_STROBE: begin
          if (r_cnt == '0) begin
            r_wr    <= 1'b0;
            r_cnt   <= cnt_load(WR_HOLD);
            r_state <= ST_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          if (r_cnt == '0) begin
            r_d_oe  <= 1'b0;
            r_gcnt  <= cnt_load(GUARD);
            r_state <= ST_GUARD_WAIT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GUARD_WAIT: begin
          // Flags are ignored here while the synchronisers catch up with the device.
          if (r_gcnt == '0) r_state <= ST_IDLE;
          else              r_gcnt  <= r_gcnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign d_o      = r_d_o;
  assign d_oe     = r_d_oe;
  assign rd_n     = r_rd_n;
  assign wr       = r_wr;
  assign tx_ready = w_wr_grant;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state != ST_IDLE);
endmodule
